// File: rtl/trap_seq.sv
// Writeback trap sequencer: arbitrates interrupts against ecall/mret, pulses the CSR
// updates, flushes the pipeline, then holds a PC redirect until the IFU accepts it.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module trap_seq #(
  parameter int FLUSH_CYC = 2,
  parameter int HOLDOFF   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wbu_valid,
  input  logic                  i_wbu_ready,
  input  logic [`CPU_WIDTH-1:0] i_wbu_pc,
  input  logic                  i_wbu_ecall,
  input  logic                  i_wbu_mret,
  input  logic                  i_wbu_nop,
  input  logic [`CPU_WIDTH-1:0] i_mip,
  input  logic [`CPU_WIDTH-1:0] i_mie,
  input  logic [`CPU_WIDTH-1:0] i_mstatus,
  input  logic [`CPU_WIDTH-1:0] i_mtvec,
  input  logic [`CPU_WIDTH-1:0] i_mepc,
  input  logic                  i_ifu_ready,
  output logic                  o_busy,
  output logic                  o_flush,
  output logic                  o_redirect_valid,
  output logic [`CPU_WIDTH-1:0] o_redirect_pc,
  output logic                  o_mepc_wen,
  output logic [`CPU_WIDTH-1:0] o_mepc_wdata,
  output logic                  o_mcause_wen,
  output logic [`CPU_WIDTH-1:0] o_mcause_wdata,
  output logic                  o_mstatus_wen,
  output logic [`CPU_WIDTH-1:0] o_mstatus_wdata
);

  localparam int W  = `CPU_WIDTH;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [W-1:0]   target_q, target_d;
  logic           flush_q, flush_d;
  logic           redir_valid_q, redir_valid_d;
  logic [W-1:0]   redir_pc_q, redir_pc_d;
  logic           mepc_wen_q, mepc_wen_d;
  logic [W-1:0]   mepc_wdata_q, mepc_wdata_d;
  logic           mcause_wen_q, mcause_wen_d;
  logic [W-1:0]   mcause_wdata_q, mcause_wdata_d;
  logic           mstatus_wen_q, mstatus_wen_d;
  logic [W-1:0]   mstatus_wdata_q, mstatus_wdata_d;

  logic           commit, irq, exc, take_trap, take_mret;
  logic [2:0]     irq_pend;
  logic [3:0]     irq_code;
  logic [W-1:0]   mcause_val, mstatus_trap, mstatus_ret;
  logic           unused_irq_bits;

  assign unused_irq_bits = ^{i_mip, i_mie};

  // Trap decision; an interrupt wins over ecall/mret on the same instruction.
  always_comb begin
    irq_pend  = {i_mip[11] & i_mie[11], i_mip[3] & i_mie[3], i_mip[7] & i_mie[7]};
    commit    = i_wbu_valid & i_wbu_ready & ~i_wbu_nop;
    irq       = i_wbu_valid & ~i_wbu_nop & i_mstatus[3] & (|irq_pend) & (hold_cnt_q == '0);
    exc       = commit & (i_wbu_ecall | i_wbu_mret);
    take_trap = irq | (exc & i_wbu_ecall);
    take_mret = ~irq & exc & ~i_wbu_ecall;

    if (irq_pend[2]) begin
      irq_code = 4'd11;
    end else if (irq_pend[1]) begin
      irq_code = 4'd3;
    end else begin
      irq_code = 4'd7;
    end

    if (irq) begin
      mcause_val = {1'b1, {(W-5){1'b0}}, irq_code};
    end else begin
      mcause_val = {{(W-4){1'b0}}, 4'd11};
    end

    mstatus_trap        = i_mstatus;
    mstatus_trap[7]     = i_mstatus[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_ret         = i_mstatus;
    mstatus_ret[3]      = i_mstatus[7];
    mstatus_ret[7]      = 1'b1;
    mstatus_ret[12:11]  = 2'b00;
  end

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    target_d        = target_q;
    flush_d         = 1'b0;
    redir_valid_d   = 1'b0;
    redir_pc_d      = '0;
    mepc_wen_d      = 1'b0;
    mepc_wdata_d    = '0;
    mcause_wen_d    = 1'b0;
    mcause_wdata_d  = '0;
    mstatus_wen_d   = 1'b0;
    mstatus_wdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (commit && hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
        if (take_trap || take_mret) begin
          state_d         = FLUSH;
          flush_cnt_d     = '0;
          flush_d         = 1'b1;
          mstatus_wen_d   = 1'b1;
          if (take_trap) begin
            mepc_wen_d      = 1'b1;
            mepc_wdata_d    = i_wbu_pc;
            mcause_wen_d    = 1'b1;
            mcause_wdata_d  = mcause_val;
            mstatus_wdata_d = mstatus_trap;
            target_d        = i_mtvec;
          end else begin
            mstatus_wdata_d = mstatus_ret;
            target_d        = i_mepc;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d       = REDIR;
          redir_valid_d = 1'b1;
          redir_pc_d    = target_q;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
          flush_d     = 1'b1;
        end
      end
      REDIR: begin
        // The redirect is held until the IFU takes it; holdoff restarts on acceptance.
        if (i_ifu_ready) begin
          state_d    = IDLE;
          hold_cnt_d = HOLD_INIT;
        end else begin
          redir_valid_d = 1'b1;
          redir_pc_d    = target_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= IDLE;
      flush_cnt_q     <= '0;
      hold_cnt_q      <= '0;
      target_q        <= '0;
      flush_q         <= 1'b0;
      redir_valid_q   <= 1'b0;
      redir_pc_q      <= '0;
      mepc_wen_q      <= 1'b0;
      mepc_wdata_q    <= '0;
      mcause_wen_q    <= 1'b0;
      mcause_wdata_q  <= '0;
      mstatus_wen_q   <= 1'b0;
      mstatus_wdata_q <= '0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      target_q        <= target_d;
      flush_q         <= flush_d;
      redir_valid_q   <= redir_valid_d;
      redir_pc_q      <= redir_pc_d;
      mepc_wen_q      <= mepc_wen_d;
      mepc_wdata_q    <= mepc_wdata_d;
      mcause_wen_q    <= mcause_wen_d;
      mcause_wdata_q  <= mcause_wdata_d;
      mstatus_wen_q   <= mstatus_wen_d;
      mstatus_wdata_q <= mstatus_wdata_d;
    end
  end

  assign o_busy           = (state_q != IDLE);
  assign o_flush          = flush_q;
  assign o_redirect_valid = redir_valid_q;
  assign o_redirect_pc    = redir_pc_q;
  assign o_mepc_wen       = mepc_wen_q;
  assign o_mepc_wdata     = mepc_wdata_q;
  assign o_mcause_wen     = mcause_wen_q;
  assign o_mcause_wdata   = mcause_wdata_q;
  assign o_mstatus_wen    = mstatus_wen_q;
  assign o_mstatus_wdata  = mstatus_wdata_q;

endmodule
